// File: rtl/processor_defs.sv
// Shared definitions for the program loader: FSM states, frame
// constants and the RAM write-strobe polarity used by mem_control_unit.
package processor_defs;

    localparam int   LEN_W          = 16;
    localparam int   BYTES_PER_WORD = 4;
    localparam int   WORD_W         = 32;
    localparam logic RAM_WR         = 1'b1;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic accepts(state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) ||
               (s == S_DATA)   || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write-port bundle of the program loader.
// The loader is the slave; the byte source / RAM side is the master.
interface program_loader_if;
    import processor_defs::*;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_rw;
    logic [LEN_W-1:0]  mem_address;
    logic [WORD_W-1:0] mem_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_rw, mem_address, mem_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_rw, mem_address, mem_data
    );

endinterface

// File: rtl/loader_word_packer.sv
// Big-endian byte-to-word shifter with a 2-bit byte index and a running
// XOR over every byte of the frame.
module loader_word_packer
    import processor_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              pack,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full,
    output logic [7:0]        xor_acc
);

    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_idx;
    logic [7:0]        r_xor;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_word <= '0;
            r_idx  <= '0;
            r_xor  <= '0;
        end else if (load) begin
            r_xor <= r_xor ^ byte_data;
            // Only payload bytes go into the word; header bytes just feed the XOR.
            if (pack) begin
                r_word <= {r_word[WORD_W-9:0], byte_data};
                r_idx  <= r_idx + 2'd1;
            end
        end
    end

    assign word      = r_word;
    assign xor_acc   = r_xor;
    assign word_full = load && pack &&
                       (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: unpacks a framed byte stream into RAM words and
// releases the core from reset only after a verified image.
module program_loader
    import processor_defs::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_WORDS);

    state_t             r_state;
    state_t             w_next;
    logic               r_byte_ready;
    logic               r_mem_rw;
    logic [LEN_W-1:0]   r_addr;
    logic [7:0]         r_len_hi;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_words;
    logic               r_done;
    logic               r_error;
    logic               r_core_reset;

    logic               w_hs;
    logic [LEN_W-1:0]   w_len;
    logic [WORD_W-1:0]  w_word;
    logic               w_full;
    logic [7:0]         w_xor;
    logic               w_clear;

    assign w_hs    = bus.byte_valid && r_byte_ready;
    assign w_len   = {r_len_hi, bus.byte_data};
    assign w_clear = (r_state == S_LEN_HI) && !w_hs;

    loader_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .load      (w_hs),
        .pack      (r_state == S_DATA),
        .byte_data (bus.byte_data),
        .word      (w_word),
        .word_full (w_full),
        .xor_acc   (w_xor)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LEN_HI: if (w_hs) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_hs) begin
                    if ({1'b0, w_len} > MAX_LEN) w_next = S_ERROR;
                    else if (w_len == '0)        w_next = S_CSUM;
                    else                         w_next = S_DATA;
                end
            end
            S_DATA:  if (w_full) w_next = S_WRITE;
            S_WRITE: begin
                if (r_words + 16'd1 == r_len) w_next = S_CSUM;
                else                          w_next = S_DATA;
            end
            S_CSUM: begin
                if (w_hs) begin
                    w_next = (bus.byte_data == w_xor) ? S_DONE : S_ERROR;
                end
            end
            default: w_next = r_state;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_LEN_HI;
            r_byte_ready <= 1'b0;
            r_mem_rw     <= !RAM_WR;
            r_addr       <= BASE_ADDR;
            r_len_hi     <= '0;
            r_len        <= '0;
            r_words      <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_reset <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= accepts(w_next);
            r_mem_rw     <= (w_next == S_WRITE) ? RAM_WR : !RAM_WR;
            if (r_state == S_LEN_HI && w_hs) r_len_hi <= bus.byte_data;
            if (r_state == S_LEN_LO && w_hs) r_len <= w_len;
            if (r_state == S_WRITE) begin
                r_addr  <= r_addr + 16'd1;
                r_words <= r_words + 16'd1;
            end
            if (w_next == S_DONE) begin
                r_done       <= 1'b1;
                r_core_reset <= 1'b1;
            end
            if (w_next == S_ERROR) r_error <= 1'b1;
        end
    end

    assign bus.byte_ready  = r_byte_ready;
    assign bus.mem_rw      = r_mem_rw;
    assign bus.mem_address = r_addr;
    assign bus.mem_data    = w_word;
    assign core_reset      = r_core_reset;
    assign done            = r_done;
    assign error           = r_error;
    assign words_loaded    = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected RAM writes are queued as
// bytes are sent and checked as mem_rw strobes appear.
module tb_program_loader;
    import processor_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    program_loader_if bus();

    program_loader #(
        .BASE_ADDR (16'h0000),
        .MAX_WORDS (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_wr = 0;
    int          n_overlap = 0;
    logic [47:0] sb[$];
    logic [31:0] img[$];
    logic [15:0] exp_addr;

    task automatic tick();
        logic [47:0] e;
        if (bus.mem_rw && bus.byte_valid && bus.byte_ready) n_overlap++;
        @(posedge clk);
        #1;
        if (bus.mem_rw) begin
            n_wr++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write got %h/%h required none",
                         bus.mem_address, bus.mem_data);
            end else begin
                e = sb.pop_front();
                if ({bus.mem_address, bus.mem_data} !== e) begin
                    n_bad++;
                    $display("FAIL write got %h/%h required %h/%h",
                             bus.mem_address, bus.mem_data,
                             e[47:32], e[31:0]);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        logic hs;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.byte_valid = 1'b0;
                tick();
            end
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int i = 0; i < 20; i++) begin
            hs = bus.byte_ready;
            tick();
            if (hs) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL byte_timeout got no handshake required one for %h", b);
    endtask

    task automatic send_frame(input logic [15:0] len, input int nw,
                              input bit bad_cs, input logic [7:0] cs,
                              input bit gaps);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        x = len[15:8] ^ len[7:0];
        send_byte(len[15:8], gaps);
        send_byte(len[7:0], gaps);
        for (int k = 0; k < nw; k++) begin
            w = img[k];
            for (int j = 0; j < 4; j++) begin
                b = w[31 - 8*j -: 8];
                x = x ^ b;
                if (j == 3) begin
                    sb.push_back({exp_addr, w});
                    exp_addr = exp_addr + 16'd1;
                end
                send_byte(b, gaps);
            end
        end
        send_byte(bad_cs ? cs : x, gaps);
    endtask

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        sb.delete();
        exp_addr = 16'h0000;
        n_wr = 0;
    endtask

    task automatic test_reset();
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.byte_ready, bus.mem_rw, core_reset, done, error} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b required 00000",
                     {bus.byte_ready, bus.mem_rw, core_reset, done, error});
        end
        n_cmp++;
        if ({bus.mem_address, bus.mem_data, words_loaded} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_values got %h/%h/%h required 0/0/0",
                     bus.mem_address, bus.mem_data, words_loaded);
        end
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        sb.delete();
        exp_addr = 16'h0000;
        n_wr = 0;
        tick();
        n_cmp++;
        if (bus.byte_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset got %b required 1", bus.byte_ready);
        end
    endtask

    task automatic test_normal();
        do_reset();
        img = '{32'hDEADBEEF, 32'h01234567};
        send_frame(16'h0002, 2, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if ({done, core_reset, error} !== 3'b110) begin
            n_bad++;
            $display("FAIL normal_flags got %b required 110",
                     {done, core_reset, error});
        end
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (n_wr !== 2 || sb.size() != 0 || words_loaded !== 16'd2) begin
            n_bad++;
            $display("FAIL normal_count got %0d/%0d/%0d required 2/0/2",
                     n_wr, sb.size(), words_loaded);
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        img = '{32'hDEADBEEF, 32'h01234567};
        send_frame(16'h0002, 2, 1'b1, 8'h00, 1'b0);
        n_cmp++;
        if ({done, core_reset, error} !== 3'b001) begin
            n_bad++;
            $display("FAIL badcs_flags got %b required 001",
                     {done, core_reset, error});
        end
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (n_wr !== 2 || bus.byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL badcs_writes got %0d/%b required 2/0",
                     n_wr, bus.byte_ready);
        end
    endtask

    task automatic test_oversize();
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        n_cmp++;
        if ({error, done, core_reset, bus.byte_ready} !== 4'b1000) begin
            n_bad++;
            $display("FAIL oversize_flags got %b required 1000",
                     {error, done, core_reset, bus.byte_ready});
        end
        bus.byte_data = 8'h33;
        repeat (10) tick();
        n_cmp++;
        if (n_wr !== 0 || bus.byte_ready !== 1'b0 || words_loaded !== 16'd0) begin
            n_bad++;
            $display("FAIL oversize_idle got %0d/%b/%0d required 0/0/0",
                     n_wr, bus.byte_ready, words_loaded);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        send_frame(16'h0000, 0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if ({done, core_reset, error} !== 3'b110) begin
            n_bad++;
            $display("FAIL zero_flags got %b required 110",
                     {done, core_reset, error});
        end
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (n_wr !== 0 || words_loaded !== 16'd0) begin
            n_bad++;
            $display("FAIL zero_writes got %0d/%0d required 0/0",
                     n_wr, words_loaded);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        img = '{32'hDEADBEEF, 32'h01234567};
        send_frame(16'h0002, 2, 1'b0, 8'h00, 1'b1);
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (!done || error || n_wr !== 2 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL gaps got %b%b/%0d/%0d required 10/2/0",
                     done, error, n_wr, sb.size());
        end
        n_cmp++;
        if (n_overlap !== 0) begin
            n_bad++;
            $display("FAIL overlap got %0d required 0", n_overlap);
        end
    endtask

    task automatic test_max_len();
        do_reset();
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back($urandom());
        send_frame(16'h0100, 256, 1'b0, 8'h00, 1'b0);
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (!done || error || n_wr !== 256 || words_loaded !== 16'd256) begin
            n_bad++;
            $display("FAIL maxlen got %b%b/%0d/%0d required 10/256/256",
                     done, error, n_wr, words_loaded);
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        bus.byte_valid = 1'b0;
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({bus.byte_ready, bus.mem_rw, core_reset, done, error} !== 5'b0 ||
            {bus.mem_address, bus.mem_data, words_loaded} !== 64'h0) begin
            n_bad++;
            $display("FAIL mid_reset got %b %h/%h/%h required 00000 0/0/0",
                     {bus.byte_ready, bus.mem_rw, core_reset, done, error},
                     bus.mem_address, bus.mem_data, words_loaded);
        end
        reset = 1'b1;
        sb.delete();
        exp_addr = 16'h0000;
        n_wr = 0;
        img = '{32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0};
        send_frame(16'h0003, 3, 1'b0, 8'h00, 1'b0);
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (!done || !core_reset || n_wr !== 3 || words_loaded !== 16'd3) begin
            n_bad++;
            $display("FAIL mid_reload got %b%b/%0d/%0d required 11/3/3",
                     done, core_reset, n_wr, words_loaded);
        end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        exp_addr       = 16'h0000;
        test_reset();
        test_normal();
        test_bad_csum();
        test_oversize();
        test_zero_len();
        test_back_to_back();
        test_max_len();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
